arbiter_control: RTL and testbench
==================================

# arbiter_control

Control FSM for the shared-memory arbiter: decides which cache (instruction or data) owns the single physical memory port and drives every select line of the arbiter datapath mux network. It sits directly upstream of the arbiter datapath, consuming the caches' request strobes and the memory's `mem_resp`. It enforces one outstanding transaction at a time, a one-cycle release gap, and bounded instruction-side starvation.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data-side grants allowed while an instruction request waits; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_read`  in  1  instruction cache read request.
- `dmem_read`  in  1  data cache read request.
- `dmem_write`  in  1  data cache write request.
- `mem_resp`  in  1  physical memory done strobe.
- `read_mux_sel`  out  2  0 idle, 1 dmem, 2 imem.
- `addr_mux_sel`  out  2  encoded the same as `read_mux_sel`.
- `write_mux_sel`  out  1  1 = pass `dmem_write`.
- `wdata_mux_sel`  out  1  1 = pass data-cache write data.
- `dmem_resp_mux_sel`  out  1  1 = route `mem_resp` to the data cache.
- `imem_resp_mux_sel`  out  1  1 = route `mem_resp` to the instruction cache.
- `dmem_rdata_mux_sel`  out  1  1 = route `mem_rdata` to the data cache.
- `imem_rdata_mux_sel`  out  1  1 = route `mem_rdata` to the instruction cache.

## Operation
- States: IDLE, SERVE_D, SERVE_I, RELEASE. Reset state is IDLE.
- Request definitions:
  - `d_req = dmem_read | dmem_write`.
  - `i_req = imem_read`.
- IDLE transitions:
  - `d_req` only -> SERVE_D.
  - `i_req` only -> SERVE_I.
  - Both -> arbitration policy (below).
  - Neither -> stay in IDLE.
- SERVE_x: hold the state until `mem_resp`=1, then go to RELEASE.
  - No timeout.
  - Request deassertion mid-transaction is ignored; the grant holds until `mem_resp`.
- RELEASE: lasts exactly one cycle, then IDLE. This gap lets the served cache drop its request so a stale request is not re-granted.
- Outputs are Moore, decoded from state only:
  - IDLE/RELEASE: all selects 0.
  - SERVE_D: `read_mux_sel`=1, `addr_mux_sel`=1, `write_mux_sel`=1, `wdata_mux_sel`=1, `dmem_resp_mux_sel`=1, `dmem_rdata_mux_sel`=1. All others 0.
  - SERVE_I: `read_mux_sel`=2, `addr_mux_sel`=2, `imem_resp_mux_sel`=1, `imem_rdata_mux_sel`=1. All others 0.
- Default policy (fixed priority with starvation guard):
  - `starve_cnt` is a saturating counter, 4 bits wide, reset value 0.
  - It increments on every IDLE->SERVE_D transition taken while `i_req`=1.
  - It clears on every IDLE->SERVE_I transition.
  - When both request: if `starve_cnt` equals `STARVE_LIMIT`, grant I; otherwise grant D.
- `mem_resp` seen in IDLE or RELEASE is ignored; no state change.
- `dmem_read` and `dmem_write` both high is treated as a single data transaction. The datapath passes both strobes; the data cache must not do this.

## Timing
- Reset: all outputs 0, state IDLE, `starve_cnt`=0.
  - Reset is asynchronous, taking effect immediately regardless of clock.
  - Reset mid-transaction abandons the transaction; selects drop in the same instant.
- Grant latency: a request sampled high at edge N produces selects valid after edge N, so `mem_read`/`mem_write` reach memory 1 cycle after the request.
- Response path: `mem_resp` propagates combinationally through the datapath to the owner's resp/rdata in the same cycle. State leaves SERVE_x at the next edge.
- Minimum transaction period: 3 cycles (grant, `mem_resp` in the first SERVE cycle, RELEASE). Back-to-back grants are separated by one RELEASE plus one IDLE cycle.
- Simultaneous requests arriving in RELEASE are not sampled until IDLE.

## Configuration
- `ARBITER_ROUND_ROBIN_EN`:
  - Defined: when both request, grant the side not granted last. A one-bit `last_grant` register holds the side last granted; reset value is imem, so D wins the first tie. `starve_cnt` and `STARVE_LIMIT` are not implemented.
  - Undefined: fixed data priority with the starvation guard, as described under Operation.

## Test plan
- Reset hold:
  - Stimulus: `rst_n`=0 with `imem_read`=1, `mem_resp`=1.
  - Response: all selects stay 0. After deassertion and one edge, `read_mux_sel`=2.
- Single D write:
  - Stimulus: `dmem_write`=1 at cycle 0, `mem_resp` pulsed at cycle 3.
  - Response: `write_mux_sel`=`wdata_mux_sel`=1 in cycles 1-3; RELEASE at cycle 4 with all selects 0; IDLE at cycle 5.
- Tie, default build, `STARVE_LIMIT`=2:
  - Stimulus: `d_req` and `i_req` held continuously, `mem_resp` 1 cycle after each grant.
  - Response: grant order D, D, I, D, D, I.
- Tie, `ARBITER_ROUND_ROBIN_EN` defined:
  - Stimulus: same as the previous scenario.
  - Response: grant order D, I, D, I.
- Stray response:
  - Stimulus: `mem_resp`=1 in IDLE and in RELEASE.
  - Response: no state change, no resp select asserted.
- Mid-transaction reset:
  - Stimulus: assert `rst_n`=0 in SERVE_I.
  - Response: `imem_resp_mux_sel` falls asynchronously. After release, a pending `dmem_read` is granted within 1 edge.

Source files
------------

// File: rtl/arbiter_control.sv
// arbiter_control -- control FSM for the shared-memory arbiter.
//
// Decides whether the instruction cache or the data cache owns the single
// physical memory port and drives every select of the arbiter datapath mux
// network. One transaction is outstanding at a time; a one-cycle RELEASE gap
// follows each response so the served cache can drop its stale request.
//
// Build option:
//   ARBITER_ROUND_ROBIN_EN  defined   -> ties alternate sides (last_grant_q)
//                           undefined -> data priority with starvation guard
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_read             instruction cache read request
//   dmem_read, dmem_write data cache read / write requests
//   mem_resp              physical memory done strobe
//   read_mux_sel[1:0]     0 idle, 1 dmem, 2 imem
//   addr_mux_sel[1:0]     same encoding as read_mux_sel
//   write_mux_sel         1 = pass dmem_write
//   wdata_mux_sel         1 = pass data-cache write data
//   dmem_resp_mux_sel     1 = route mem_resp to data cache
//   imem_resp_mux_sel     1 = route mem_resp to instruction cache
//   dmem_rdata_mux_sel    1 = route mem_rdata to data cache
//   imem_rdata_mux_sel    1 = route mem_rdata to instruction cache
module arbiter_control #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       imem_read,
    input  logic       dmem_read,
    input  logic       dmem_write,
    input  logic       mem_resp,
    output logic [1:0] read_mux_sel,
    output logic [1:0] addr_mux_sel,
    output logic       write_mux_sel,
    output logic       wdata_mux_sel,
    output logic       dmem_resp_mux_sel,
    output logic       imem_resp_mux_sel,
    output logic       dmem_rdata_mux_sel,
    output logic       imem_rdata_mux_sel
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic d_req, i_req;
    logic tie_grant_i;   // on a tie, 1 = instruction side wins

    assign d_req = dmem_read | dmem_write;
    assign i_req = imem_read;

`ifdef ARBITER_ROUND_ROBIN_EN
    // 1 = instruction side was granted last. Resets to imem so D wins the
    // first tie.
    logic last_grant_q, last_grant_d;

    assign tie_grant_i = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && state_d == SERVE_D) last_grant_d = 1'b0;
        if (state_q == IDLE && state_d == SERVE_I) last_grant_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`else
    // Counts data grants won while an instruction request was waiting;
    // saturates so a long data burst cannot wrap it back below the limit.
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign tie_grant_i = (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE && state_d == SERVE_D && i_req && starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;
        if (state_q == IDLE && state_d == SERVE_I)
            starve_cnt_d = 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= 4'd0;
        else        starve_cnt_q <= starve_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state. mem_resp outside SERVE_x is ignored by construction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && i_req) state_d = tie_grant_i ? SERVE_I : SERVE_D;
                else if (d_req)     state_d = SERVE_D;
                else if (i_req)     state_d = SERVE_I;
            end
            SERVE_D, SERVE_I: if (mem_resp) state_d = RELEASE;
            RELEASE:          state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // Moore outputs straight from the state register, so an asynchronous
    // reset drops every select in the same instant.
    always_comb begin
        read_mux_sel       = 2'd0;
        addr_mux_sel       = 2'd0;
        write_mux_sel      = 1'b0;
        wdata_mux_sel      = 1'b0;
        dmem_resp_mux_sel  = 1'b0;
        imem_resp_mux_sel  = 1'b0;
        dmem_rdata_mux_sel = 1'b0;
        imem_rdata_mux_sel = 1'b0;
        case (state_q)
            SERVE_D: begin
                read_mux_sel       = 2'd1;
                addr_mux_sel       = 2'd1;
                write_mux_sel      = 1'b1;
                wdata_mux_sel      = 1'b1;
                dmem_resp_mux_sel  = 1'b1;
                dmem_rdata_mux_sel = 1'b1;
            end
            SERVE_I: begin
                read_mux_sel       = 2'd2;
                addr_mux_sel       = 2'd2;
                imem_resp_mux_sel  = 1'b1;
                imem_rdata_mux_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arbiter_control.sv
module tb_arbiter_control;

    localparam int LIMIT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_read = 1'b0, dmem_read = 1'b0, dmem_write = 1'b0, mem_resp = 1'b0;
    logic [1:0] read_mux_sel, addr_mux_sel;
    logic       write_mux_sel, wdata_mux_sel, dmem_resp_mux_sel, imem_resp_mux_sel;
    logic       dmem_rdata_mux_sel, imem_rdata_mux_sel;

    int errors = 0;
    int checks = 0;

    arbiter_control #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mem_resp(mem_resp),
        .read_mux_sel(read_mux_sel), .addr_mux_sel(addr_mux_sel),
        .write_mux_sel(write_mux_sel), .wdata_mux_sel(wdata_mux_sel),
        .dmem_resp_mux_sel(dmem_resp_mux_sel), .imem_resp_mux_sel(imem_resp_mux_sel),
        .dmem_rdata_mux_sel(dmem_rdata_mux_sel), .imem_rdata_mux_sel(imem_rdata_mux_sel)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the memory port (0 nobody, 1 data, 2 instr),
    // whether we are in the post-response gap, and the fairness history.
    int owner;
    bit gap;
    int starve;
    bit last_was_i;

    function automatic void model_reset();
        owner = 0; gap = 0; starve = 0; last_was_i = 1;
    endfunction

    function automatic void model_step(bit ir, bit dr, bit dw, bit rsp);
        int win;
        if (gap) gap = 0;
        else if (owner != 0) begin
            if (rsp) begin owner = 0; gap = 1; end
        end else begin
            win = 0;
            if ((dr || dw) && ir) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                win = last_was_i ? 1 : 2;
`else
                win = (starve == LIMIT) ? 2 : 1;
`endif
            end else if (dr || dw) win = 1;
            else if (ir) win = 2;
            if (win == 1 && ir && starve < 15) starve++;
            if (win == 2) starve = 0;
            if (win != 0) last_was_i = (win == 2);
            owner = win;
        end
    endfunction

    function automatic logic [9:0] model_outs();
        if (owner == 1) return {2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        if (owner == 2) return {2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        return 10'd0;
    endfunction

    function automatic logic [9:0] dut_outs();
        return {read_mux_sel, addr_mux_sel, write_mux_sel, wdata_mux_sel,
                dmem_resp_mux_sel, imem_resp_mux_sel, dmem_rdata_mux_sel, imem_rdata_mux_sel};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs away from the edge, advance model, sample #1 after.
    task automatic cyc(input string tag, input bit ir, input bit dr, input bit dw, input bit rsp);
        imem_read = ir; dmem_read = dr; dmem_write = dw; mem_resp = rsp;
        model_step(ir, dr, dw, rsp);
        @(posedge clk); #1;
        chk(tag, dut_outs(), model_outs());
    endtask

    task automatic do_reset();
        imem_read = 0; dmem_read = 0; dmem_write = 0; mem_resp = 0;
        rst_n = 0; model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    int grants[$];
    int exp_grants[6];
    logic [1:0] prev_sel;
    bit rsp;

    initial begin
        model_reset();
        // Reset hold with requests and a response present.
        rst_n = 0; imem_read = 1; mem_resp = 1;
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", dut_outs(), 10'd0);
        rst_n = 1;
        cyc("reset_release_grant", 1, 0, 0, 0);
        chk("reset_release_imem", {8'd0, read_mux_sel}, 10'd2);
        cyc("finish_i", 0, 0, 0, 1);
        cyc("idle_after_i", 0, 0, 0, 0);

        // Single data write, response at cycle 3.
        cyc("dw_c1", 0, 0, 1, 0);
        chk("dw_write_sel", {8'd0, write_mux_sel, wdata_mux_sel}, 10'd3);
        cyc("dw_c2", 0, 0, 1, 0);
        cyc("dw_c3", 0, 0, 1, 1);
        chk("dw_release", dut_outs(), 10'd0);
        cyc("dw_idle", 0, 0, 0, 0);

        // Stray responses in IDLE and in RELEASE.
        cyc("stray_idle", 0, 0, 0, 1);
        chk("stray_idle_zero", dut_outs(), 10'd0);
        cyc("stray_grant", 0, 1, 0, 0);
        cyc("stray_resp", 0, 0, 0, 1);
        cyc("stray_release", 0, 0, 0, 1);
        chk("stray_release_zero", dut_outs(), 10'd0);

        // Persistent tie; response in the first cycle of each grant.
        do_reset();
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_grants = '{1, 2, 1, 2, 1, 2};
`else
        exp_grants = '{1, 1, 2, 1, 1, 2};
`endif
        prev_sel = 2'd0;
        for (int c = 0; c < 18; c++) begin
            rsp = (owner != 0 && !gap);
            cyc("tie", 1, 1, 0, rsp);
            if (prev_sel == 2'd0 && read_mux_sel != 2'd0) grants.push_back(int'(read_mux_sel));
            prev_sel = read_mux_sel;
        end
        chk("tie_count", 10'(grants.size()), 10'd6);
        for (int g = 0; g < 6 && g < grants.size(); g++)
            chk($sformatf("tie_grant%0d", g), 10'(grants[g]), 10'(exp_grants[g]));

        // Reset in the middle of an instruction transaction.
        do_reset();
        cyc("mid_grant_i", 1, 0, 0, 0);
        chk("mid_serve_i", {9'd0, imem_resp_mux_sel}, 10'd1);
        #2 rst_n = 0;
        #1 chk("mid_async_drop", {9'd0, imem_resp_mux_sel}, 10'd0);
        model_reset();
        #1 rst_n = 1;
        cyc("mid_dread", 0, 1, 0, 0);
        chk("mid_dread_sel", {8'd0, read_mux_sel}, 10'd1);
        cyc("mid_finish", 0, 0, 0, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cyc("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
